// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin scheduler sharing one i2c master between NREQ requesters,
// with start/busy timeouts and an idle gap between transactions.
module i2c_master_arbiter #(
    parameter int NREQ     = 4,
    parameter int START_TO = 1024,
    parameter int BUSY_TO  = 16384,
    parameter int GAP      = 256
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [NREQ-1:0]   req,
    input  logic [7*NREQ-1:0] req_addr,
    input  logic [NREQ-1:0]   req_rw,
    input  logic [8*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              err,
    output logic [7:0]        rdata,
    output logic              m_en,
    output logic [6:0]        m_addr,
    output logic              m_rw,
    output logic [7:0]        m_data_in,
    input  logic              m_busy,
    input  logic [7:0]        m_data_out
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, COMPLETE, GAP_WAIT} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d, idx_q, idx_d, sel, cand;
    logic            found, sel_rw;
    logic [6:0]      sel_addr;
    logic [7:0]      sel_wdata;
    logic [15:0]     cnt_q, cnt_d;
    logic            to_q, to_d;
    logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
    logic            err_q, err_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            m_en_q, m_en_d;
    logic [6:0]      m_addr_q, m_addr_d;
    logic            m_rw_q, m_rw_d;
    logic [7:0]      m_data_q, m_data_d;

    // Reverse scan so the candidate closest to the pointer wins.
    always_comb begin
        sel       = '0;
        cand      = '0;
        found     = 1'b0;
        sel_addr  = '0;
        sel_rw    = 1'b0;
        sel_wdata = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = PW'((int'(ptr_q) + i) % NREQ);
            if (req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (PW'(k) == sel) begin
                sel_addr  = req_addr[7*k +: 7];
                sel_rw    = req_rw[k];
                sel_wdata = req_wdata[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        to_d     = to_q;
        gnt_d    = '0;
        done_d   = '0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        m_en_d   = m_en_q;
        m_addr_d = m_addr_q;
        m_rw_d   = m_rw_q;
        m_data_d = m_data_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    m_addr_d = sel_addr;
                    m_rw_d   = sel_rw;
                    m_data_d = sel_wdata;
                    gnt_d    = NREQ'(1) << sel;
                    idx_d    = sel;
                    ptr_d    = (sel == PW'(NREQ - 1)) ? '0 : sel + PW'(1);
                    cnt_d    = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // The start budget counts only cycles in which en is actually driven high.
                m_en_d = 1'b1;
                cnt_d  = cnt_q + 16'(m_en_q);
                if (m_en_q && m_busy) begin
                    m_en_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = WAIT_BUSY;
                end else if (m_en_q && cnt_q == 16'(START_TO - 1)) begin
                    m_en_d  = 1'b0;
                    to_d    = 1'b1;
                    state_d = COMPLETE;
                end
            end
            WAIT_BUSY: begin
                m_en_d = 1'b0;
                cnt_d  = cnt_q + 16'd1;
                if (!m_busy) begin
                    state_d = COMPLETE;
                end else if (cnt_q == 16'(BUSY_TO - 1)) begin
                    to_d    = 1'b1;
                    state_d = COMPLETE;
                end
            end
            COMPLETE: begin
                done_d  = NREQ'(1) << idx_q;
                err_d   = to_q;
                rdata_d = (m_rw_q && !to_q) ? m_data_out : rdata_q;
                to_d    = 1'b0;
                cnt_d   = '0;
                state_d = GAP_WAIT;
            end
            GAP_WAIT: begin
                m_en_d  = 1'b0;
                cnt_d   = (cnt_q == 16'(GAP - 1)) ? cnt_q : cnt_q + 16'd1;
                state_d = (cnt_q == 16'(GAP - 1)) ? IDLE : GAP_WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            to_q     <= 1'b0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            m_en_q   <= 1'b0;
            m_addr_q <= '0;
            m_rw_q   <= 1'b0;
            m_data_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            m_en_q   <= m_en_d;
            m_addr_q <= m_addr_d;
            m_rw_q   <= m_rw_d;
            m_data_q <= m_data_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign m_en      = m_en_q;
    assign m_addr    = m_addr_q;
    assign m_rw      = m_rw_q;
    assign m_data_in = m_data_q;
endmodule
